face_select_scheduler: RTL and testbench
========================================

Name: face_select_scheduler

Overview:
- Owns the face_select input of the VGA display core. The display core itself is unchanged.
- Arbitrates three requesters of the displayed face: a host/sequencer handshake port, debounced slide switches, and an internal auto-cycle timer.
- Applies every change only at a vertical-sync frame boundary and holds each face for a minimum dwell, so the display never tears mid-frame.
- Sits between the board switches/sequencer logic and the display core in the top level.

Parameters:
FACE_W, 2, width of a face index
NUM_FACES, 4, number of valid faces (indices 0..NUM_FACES-1)
DWELL_FRAMES, 30, minimum frames a newly applied face is held; 0 disables dwell
AUTO_PERIOD_FRAMES, 120, idle frames between auto-cycle advances
SYNC_STAGES, 2, flops in the vsync synchronizer (minimum 2)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
vga_vs  in  1  active-low VGA vsync from the display core (asynchronous to CLOCK_50)
sw_face  in  FACE_W  raw switch face request
auto_en  in  1  enable auto-cycle
host_req_valid  in  1  host face request valid
host_req_face  in  FACE_W  host requested face
host_req_ready  out  1  scheduler can accept a host request
face_select  out  FACE_W  face index driven to the display core
frame_strobe  out  1  one-cycle pulse per detected frame start
busy  out  1  a change is pending or dwell is active

Behaviour:
- Reset values: face_select=0, host_req_ready=1, busy=0, frame_strobe=0. State=IDLE; dwell/auto counters=0; switch samples=0.
- Async reset mid-operation discards any pending face immediately.
- Frame tick:
  - vga_vs passes through SYNC_STAGES flops.
  - frame_tick is a one-cycle pulse on the synchronized 1->0 edge, two cycles after that edge is synchronized (edge register).
  - frame_strobe = frame_tick, registered once more.
- Switch debounce:
  - sw_face is sampled on each frame_tick.
  - sw_req asserts when two consecutive samples are equal and differ from face_select.
- Host handshake:
  - A transfer occurs when host_req_valid & host_req_ready in the same cycle.
  - host_req_ready = (state==IDLE).
  - A requested face >= NUM_FACES is accepted and dropped: no state change.
- Priority in IDLE: host > switch > auto. At most one request is taken per cycle.
- FSM:
  - IDLE: on a taken request, latch pending and go to PENDING.
  - IDLE auto-cycle: if auto_en and a frame_tick occurs with auto_cnt==AUTO_PERIOD_FRAMES-1, set pending=(face_select+1) mod NUM_FACES and go to PENDING.
  - PENDING, on frame_tick, pending==face_select: go to IDLE, no dwell.
  - PENDING, on frame_tick, otherwise: face_select<=pending, dwell_cnt<=0, go to DWELL. If DWELL_FRAMES==0, go to IDLE instead.
  - A request taken in the same cycle as a frame_tick is applied at the next frame_tick, not the current one.
  - DWELL: increment dwell_cnt on each frame_tick; at dwell_cnt==DWELL_FRAMES-1 with a frame_tick, go to IDLE.
- busy = (state != IDLE).
- auto_cnt:
  - Counts frame_ticks only in IDLE with auto_en=1.
  - Clears when auto_en=0, on any face_select change, and on wrap.
- Wrap-around: auto-cycle wraps NUM_FACES-1 -> 0.

Optional Feature:
FACE_SCHED_STATS_EN:
- Defined: adds output port change_count [15:0]. It increments on every actual face_select change, saturates at 16'hFFFF, and is 0 on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package face_sched_pkg holds:
  - FACE_W and NUM_FACES constants;
  - face_t typedef (logic [FACE_W-1:0]);
  - sched_state_t enum {IDLE, PENDING, DWELL}.
- Sub-module vsync_edge_detect holds the SYNC_STAGES synchronizer plus the falling-edge pulse generator. It is reusable by other frame-synchronous blocks.

Test Plan:
- Reset with sw_face=2 and auto_en=0, then 3 vga_vs falling edges -> face_select=0 until the second equal sample. face_select=2 at the following frame_tick; busy high through 30 dwell frames.
- Host request face=3 held valid in IDLE -> ready drops the next cycle. face_select=3 exactly at the next frame_tick; host_req_ready returns 1 after 30 frames.
- host_req_valid and a switch change in the same IDLE cycle -> host face applied; switch change applied only after the dwell ends.
- auto_en=1, AUTO_PERIOD_FRAMES=4, DWELL_FRAMES=0 -> face sequence 0,1,2,3,0 with each change 5 frames apart (4 idle + 1 pending).
- Host face=1 while face_select=1 -> no change, no dwell, IDLE after one frame_tick. Host face=5 with FACE_W=3 and NUM_FACES=4 -> accepted, dropped.
- Assert reset while in PENDING -> face_select=0, busy=0, host_req_ready=1 immediately (asynchronously); the pending face is never applied.

Source files
------------

// File: rtl/face_sched_pkg.sv
// Shared face-scheduler types: default face geometry, face index type and scheduler states.
package face_sched_pkg;

  localparam int FACE_W    = 2;
  localparam int NUM_FACES = 4;

  typedef logic [FACE_W-1:0] face_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    DWELL   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/vsync_edge_detect.sv
// Synchronizes an asynchronous active-low vsync and emits a one-cycle frame tick
// two cycles after a synchronized 1->0 edge; no backpressure.
module vsync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vs_n,
  output logic o_tick
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_vs_d;
  logic                   r_tick;
  logic                   w_vs_s;
  logic                   w_fall;

  assign w_vs_s = r_sync[SYNC_STAGES-1];
  assign w_fall = r_vs_d & ~w_vs_s;

  // Reset to the inactive (high) level so releasing reset never fakes a frame start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '1;
      r_vs_d <= 1'b1;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_vs_n};
      r_vs_d <= w_vs_s;
      r_tick <= w_fall;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/face_select_scheduler.sv
// Arbitrates host/switch/auto face requests, applying each at a vsync frame boundary with a dwell.
// Optional FACE_SCHED_STATS_EN adds a saturating change_count output; host waits on host_req_ready.
module face_select_scheduler
  import face_sched_pkg::*;
#(
  parameter int FACE_W             = face_sched_pkg::FACE_W,
  parameter int NUM_FACES          = face_sched_pkg::NUM_FACES,
  parameter int DWELL_FRAMES       = 30,
  parameter int AUTO_PERIOD_FRAMES = 120,
  parameter int SYNC_STAGES        = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              vga_vs,
  input  logic [FACE_W-1:0] sw_face,
  input  logic              auto_en,
  input  logic              host_req_valid,
  input  logic [FACE_W-1:0] host_req_face,
  output logic              host_req_ready,
  output logic [FACE_W-1:0] face_select,
  output logic              frame_strobe,
  output logic              busy
`ifdef FACE_SCHED_STATS_EN
  ,
  output logic [15:0]       change_count
`endif
);

  localparam int DCW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam int ACW = (AUTO_PERIOD_FRAMES > 1) ? $clog2(AUTO_PERIOD_FRAMES) : 1;
  localparam logic [DCW-1:0]    DWELL_LAST  = DCW'(DWELL_FRAMES - 1);
  localparam logic [ACW-1:0]    AUTO_LAST   = ACW'(AUTO_PERIOD_FRAMES - 1);
  localparam logic [FACE_W-1:0] FACE_LAST   = FACE_W'(NUM_FACES - 1);
  localparam logic [FACE_W:0]   FACE_LIMIT  = (FACE_W + 1)'(NUM_FACES);

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;
  logic [FACE_W-1:0] r_face;
  logic [FACE_W-1:0] r_pending;
  logic [FACE_W-1:0] r_sw_s0;
  logic [FACE_W-1:0] r_sw_s1;
  logic [DCW-1:0]    r_dwell_cnt;
  logic [ACW-1:0]    r_auto_cnt;
  logic              r_strobe;

  logic              w_tick;
  logic              w_idle;
  logic              w_host_xfer;
  logic              w_host_ok;
  logic              w_sw_req;
  logic              w_auto_fire;
  logic              w_take_host;
  logic              w_take_sw;
  logic              w_take_auto;
  logic              w_load;
  logic              w_apply;
  logic              w_change;
  logic [FACE_W-1:0] w_face_next;
  logic [FACE_W-1:0] w_req_face;

  vsync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_vsync (
    .i_clk  (CLOCK_50),
    .i_rst  (reset),
    .i_vs_n (vga_vs),
    .o_tick (w_tick)
  );

  assign w_idle      = (r_state == IDLE);
  assign w_host_xfer = host_req_valid & w_idle;
  assign w_host_ok   = w_host_xfer & ({1'b0, host_req_face} < FACE_LIMIT);
  assign w_sw_req    = (r_sw_s0 == r_sw_s1) && (r_sw_s0 != r_face) &&
                       ({1'b0, r_sw_s0} < FACE_LIMIT);
  assign w_auto_fire = auto_en && w_tick && (r_auto_cnt == AUTO_LAST);

  // One request per cycle: an out-of-range host transfer still consumes the slot.
  assign w_take_host = w_host_ok;
  assign w_take_sw   = w_idle && !w_host_xfer && w_sw_req;
  assign w_take_auto = w_idle && !w_host_xfer && !w_sw_req && w_auto_fire;
  assign w_load      = w_take_host || w_take_sw || w_take_auto;

  assign w_apply     = (r_state == PENDING) && w_tick;
  assign w_change    = w_apply && (r_pending != r_face);
  assign w_face_next = (r_face == FACE_LAST) ? '0 : r_face + FACE_W'(1);

  always_comb begin
    w_req_face = w_face_next;
    if (w_take_host) begin
      w_req_face = host_req_face;
    end else if (w_take_sw) begin
      w_req_face = r_sw_s0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (w_tick) begin
          w_state_nxt = (!w_change || DWELL_FRAMES == 0) ? IDLE : DWELL;
        end
      end
      DWELL: begin
        if (w_tick && r_dwell_cnt == DWELL_LAST) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    host_req_ready = w_idle;
    busy           = !w_idle;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_face      <= '0;
      r_pending   <= '0;
      r_sw_s0     <= '0;
      r_sw_s1     <= '0;
      r_dwell_cnt <= '0;
      r_auto_cnt  <= '0;
      r_strobe    <= 1'b0;
    end else begin
      r_strobe <= w_tick;
      if (w_load) begin
        r_pending <= w_req_face;
      end
      if (w_change) begin
        r_face <= r_pending;
      end
      if (w_tick) begin
        r_sw_s0 <= sw_face;
        r_sw_s1 <= r_sw_s0;
      end
      if (w_apply) begin
        r_dwell_cnt <= '0;
      end else if (r_state == DWELL && w_tick) begin
        r_dwell_cnt <= r_dwell_cnt + DCW'(1);
      end
      if (!auto_en || w_change) begin
        r_auto_cnt <= '0;
      end else if (w_idle && w_tick) begin
        r_auto_cnt <= (r_auto_cnt == AUTO_LAST) ? '0 : r_auto_cnt + ACW'(1);
      end
    end
  end

  assign face_select  = r_face;
  assign frame_strobe = r_strobe;

`ifdef FACE_SCHED_STATS_EN
  logic [15:0] r_change_cnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_change_cnt <= '0;
    end else if (w_change && r_change_cnt != 16'hFFFF) begin
      r_change_cnt <= r_change_cnt + 16'd1;
    end
  end

  assign change_count = r_change_cnt;
`endif

endmodule

// File: tb/tb_face_select_scheduler.sv
// Directed bench: dut_a (FACE_W=3, dwell 30) covers switch/host paths; dut_b (dwell 0, auto 4) covers auto-cycle.
module tb_face_select_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       vga_vs;

  logic [2:0] sw_a, host_face_a, face_a;
  logic       auto_a, host_vld_a, ready_a, strobe_a, busy_a;
  logic [1:0] sw_b, host_face_b, face_b;
  logic       auto_b, host_vld_b, ready_b, strobe_b, busy_b;
`ifdef FACE_SCHED_STATS_EN
  logic [15:0] cc_a, cc_b;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  face_select_scheduler #(
    .FACE_W(3), .NUM_FACES(4), .DWELL_FRAMES(30), .AUTO_PERIOD_FRAMES(120), .SYNC_STAGES(2)
  ) dut_a (
    .CLOCK_50(clk), .reset(reset), .vga_vs(vga_vs), .sw_face(sw_a), .auto_en(auto_a),
    .host_req_valid(host_vld_a), .host_req_face(host_face_a), .host_req_ready(ready_a),
    .face_select(face_a), .frame_strobe(strobe_a), .busy(busy_a)
`ifdef FACE_SCHED_STATS_EN
    , .change_count(cc_a)
`endif
  );

  face_select_scheduler #(
    .FACE_W(2), .NUM_FACES(4), .DWELL_FRAMES(0), .AUTO_PERIOD_FRAMES(4), .SYNC_STAGES(2)
  ) dut_b (
    .CLOCK_50(clk), .reset(reset), .vga_vs(vga_vs), .sw_face(sw_b), .auto_en(auto_b),
    .host_req_valid(host_vld_b), .host_req_face(host_face_b), .host_req_ready(ready_b),
    .face_select(face_b), .frame_strobe(strobe_b), .busy(busy_b)
`ifdef FACE_SCHED_STATS_EN
    , .change_count(cc_b)
`endif
  );

  always @(posedge clk) if (strobe_a) strobe_cnt <= strobe_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One video frame: 4 cycles of active-low vsync then 16 cycles high.
  task automatic frame();
    vga_vs = 1'b0;
    repeat (4) @(negedge clk);
    vga_vs = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic host_a(input logic [2:0] f);
    @(negedge clk);
    host_vld_a  = 1'b1;
    host_face_a = f;
    @(negedge clk);
    host_vld_a  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vga_vs = 1'b1;
    sw_a = 3'd2; auto_a = 1'b0; host_vld_a = 1'b0; host_face_a = 3'd0;
    sw_b = 2'd0; auto_b = 1'b0; host_vld_b = 1'b0; host_face_b = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_face_a",   face_a,   0);
    chk("rst_ready_a",  ready_a,  1);
    chk("rst_busy_a",   busy_a,   0);
    chk("rst_strobe_a", strobe_a, 0);
    chk("rst_face_b",   face_b,   0);
    reset = 1'b0;
    @(negedge clk);

    // Switch debounce: two equal samples, then applied on the third frame start.
    frames(2);
    chk("sw_hold_face", face_a, 0);
    chk("sw_pend_busy", busy_a, 1);
    frame();
    chk("sw_apply_face", face_a, 2);
    chk("sw_dwell_busy", busy_a, 1);
    chk("strobe_count",  strobe_cnt, 3);
    frames(29);
    chk("sw_dwell29_busy", busy_a, 1);
    frame();
    chk("sw_dwell_end_busy", busy_a, 0);
    chk("sw_dwell_end_rdy",  ready_a, 1);

    // Host request: ready drops next cycle, applied at next frame start.
    sw_a = 3'd3;
    host_a(3'd3);
    chk("host_rdy_drop", ready_a, 0);
    frame();
    chk("host_apply_face", face_a, 3);
    frames(29);
    chk("host_dwell_rdy", ready_a, 0);
    frame();
    chk("host_rdy_back", ready_a, 1);
    chk("host_face_keep", face_a, 3);

    // Host and switch change together: host wins, switch follows after dwell.
    @(negedge clk);
    sw_a = 3'd0;
    host_a(3'd1);
    chk("hs_busy", busy_a, 1);
    frame();
    chk("hs_host_face", face_a, 1);
    frames(29);
    chk("hs_dwell_face", face_a, 1);
    frame();
    chk("hs_sw_pend_face", face_a, 1);
    chk("hs_sw_pend_busy", busy_a, 1);
    frame();
    chk("hs_sw_apply_face", face_a, 0);
    frames(30);
    chk("hs_idle_busy", busy_a, 0);

    // Same-face host request: one pending frame, no dwell.
    host_a(3'd0);
    chk("same_busy", busy_a, 1);
    frame();
    chk("same_idle_busy", busy_a, 0);
    chk("same_face", face_a, 0);
    chk("same_rdy", ready_a, 1);

    // Out-of-range host face is accepted and dropped.
    host_a(3'd5);
    chk("oor_busy", busy_a, 0);
    chk("oor_rdy",  ready_a, 1);
    frame();
    chk("oor_face", face_a, 0);

`ifdef FACE_SCHED_STATS_EN
    chk("stats_count", cc_a, 4);
`endif

    // Auto-cycle on dut_b: 4 idle frames + 1 pending frame per step, wrapping 3 -> 0.
    @(negedge clk);
    auto_b = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      logic [1:0] prev_f, new_f;
      prev_f = 2'(k - 1);
      new_f  = 2'(k);
      frames(4);
      chk("auto_hold_face", face_b, prev_f);
      chk("auto_pend_busy", busy_b, 1);
      sw_b = new_f;
      frame();
      chk("auto_step_face", face_b, new_f);
      chk("auto_step_busy", busy_b, 0);
    end

    // Async reset while both DUTs have a pending face.
    frames(4);
    chk("pre_rst_face_b", face_b, 1);
    chk("pre_rst_busy_b", busy_b, 1);
    host_a(3'd2);
    chk("pre_rst_busy_a", busy_a, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_face_b",  face_b,  0);
    chk("arst_busy_b",  busy_b,  0);
    chk("arst_face_a",  face_a,  0);
    chk("arst_busy_a",  busy_a,  0);
    chk("arst_ready_a", ready_a, 1);
    @(negedge clk);
    reset = 1'b0; auto_b = 1'b0; sw_b = 2'd0;
    frames(2);
    chk("post_rst_face_a", face_a, 0);
    chk("post_rst_face_b", face_b, 0);
    chk("post_rst_busy_a", busy_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
